// File: rtl/port_sched_if.sv
// -----------------------------------------------------------------------------
// port_sched_if
// Bundles the signals that pass between one output-port scheduler and the rest
// of the router.
//   req_i         : per-input request (a head flit targets this output)
//   credit_incr_i : downstream freed one slot this cycle
//   grant_o       : registered one-hot grant (crossbar select / input pop)
//   grant_valid_o : OR of grant_o; a flit moves this cycle
//   credit_cnt_o  : current downstream credit count
//   stall_o       : requests pending while no credit is available
//   credit_err_o  : sticky credit-overflow flag
//   state_dbg_o   : scheduler FSM state, for observation only
// Modports: master = router side (drives requests/credits),
//           slave  = scheduler side (drives grants/status).
// Handshake: a requester holds req_i until it sees its grant_o bit; a set
// grant_o bit means that flit is transferred and popped in that same cycle.
// -----------------------------------------------------------------------------
interface port_sched_if #(
  parameter int NUM_REQ  = 5,
  parameter int CREDIT_W = 3
);
  logic [NUM_REQ-1:0]  req_i;
  logic                credit_incr_i;
  logic [NUM_REQ-1:0]  grant_o;
  logic                grant_valid_o;
  logic [CREDIT_W-1:0] credit_cnt_o;
  logic                stall_o;
  logic                credit_err_o;
  logic [1:0]          state_dbg_o;

  modport master (
    output req_i, credit_incr_i,
    input  grant_o, grant_valid_o, credit_cnt_o, stall_o, credit_err_o,
           state_dbg_o
  );

  modport slave (
    input  req_i, credit_incr_i,
    output grant_o, grant_valid_o, credit_cnt_o, stall_o, credit_err_o,
           state_dbg_o
  );
endinterface

// File: rtl/port_scheduler.sv
// -----------------------------------------------------------------------------
// port_scheduler
// Shares one router output port among NUM_REQ input buffers. Requests are
// arbitrated round-robin and gated by a downstream credit counter; the winner
// is presented as a registered one-hot grant one cycle after the request is
// sampled.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset
//   bus : port_sched_if.slave (requests, credit return, grant, status)
// Optional build macro: SCHED_LOCAL_PRIO_EN -- the local input (highest index)
//   wins over round-robin, limited to two consecutive grants while any other
//   input is requesting.
// -----------------------------------------------------------------------------
module port_scheduler #(
  parameter int NUM_REQ     = 5,
  parameter int MAX_CREDITS = 4,
  parameter int CREDIT_W    = 3
) (
  input  logic         clk,
  input  logic         rst,
  port_sched_if.slave  bus
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_GRANT     = 2'd1,
    S_NO_CREDIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [CREDIT_W-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;

  logic [NUM_REQ-1:0]  req;
  logic                any_req;
  logic [CREDIT_W:0]   avail;    // one extra bit: cnt + return can reach MAX+1
  logic [CREDIT_W:0]   sum;
  logic                can_grant;
  logic                ptr_upd;

  logic [NUM_REQ-1:0]  rr_mask;
  logic                rr_found;
  logic [PTR_W-1:0]    rr_idx;
  logic                win_found;
  logic [PTR_W-1:0]    win_idx;

  assign req     = bus.req_i;
  assign any_req = |req;
  // A credit returned this cycle can be spent by the grant issued this cycle.
  assign avail   = {1'b0, cnt_q} + {{CREDIT_W{1'b0}}, bus.credit_incr_i};

  // Round-robin search starting just after the last winner.
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!rr_found && rr_mask[idx]) begin
        rr_found = 1'b1;
        rr_idx   = PTR_W'(idx);
      end
    end
  end

`ifdef SCHED_LOCAL_PRIO_EN
  localparam int L_IDX = NUM_REQ - 1;

  logic [1:0] streak_q, streak_d;
  logic       others_req;
  logic       l_limited;
  logic       l_wins;

  always_comb begin
    others_req     = |req[NUM_REQ-2:0];
    // After two back-to-back local grants with others waiting, yield a slot.
    l_limited      = others_req && (streak_q == 2'd2);
    l_wins         = req[L_IDX] && !l_limited;
    rr_mask        = req;
    rr_mask[L_IDX] = 1'b0;
    win_found      = l_wins || rr_found;
    win_idx        = l_wins ? PTR_W'(L_IDX) : rr_idx;
  end

  always_comb begin
    streak_d = streak_q;
    if (can_grant) begin
      streak_d = (l_wins && others_req) ? streak_q + 2'd1 : 2'd0;
    end else if (req[L_IDX] && !others_req) begin
      streak_d = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) streak_q <= 2'd0;
    else     streak_q <= streak_d;
  end

  // Local grants do not move the pointer, so rotation among 0..L-1 is fair.
  assign ptr_upd = can_grant && !l_wins;
`else
  always_comb begin
    rr_mask   = req;
    win_found = rr_found;
    win_idx   = rr_idx;
  end

  assign ptr_upd = can_grant;
`endif

  assign can_grant = win_found && (avail != '0);

  // Next-state, grant, pointer and credit logic.
  always_comb begin
    state_d = S_IDLE;
    grant_d = '0;
    ptr_d   = ptr_q;
    err_d   = err_q;
    sum     = avail - {{CREDIT_W{1'b0}}, can_grant};
    cnt_d   = sum[CREDIT_W-1:0];

    if (!any_req)           state_d = S_IDLE;
    else if (avail != '0)   state_d = S_GRANT;
    else                    state_d = S_NO_CREDIT;

    if (can_grant) grant_d[win_idx] = 1'b1;
    if (ptr_upd)   ptr_d = win_idx;

    // A return with the counter already full is a protocol error; saturate.
    if (sum > (CREDIT_W+1)'(MAX_CREDITS)) begin
      cnt_d = CREDIT_W'(MAX_CREDITS);
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= PTR_W'(NUM_REQ - 1);
      cnt_q   <= CREDIT_W'(MAX_CREDITS);
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.grant_o       = grant_q;
  assign bus.grant_valid_o = |grant_q;
  assign bus.credit_cnt_o  = cnt_q;
  assign bus.stall_o       = (state_q == S_NO_CREDIT);
  assign bus.credit_err_o  = err_q;
  assign bus.state_dbg_o   = state_q;

endmodule

// File: tb/tb_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_port_scheduler
// Directed, table-driven bench for port_scheduler. Each table row holds the
// inputs for one cycle and the outputs expected just after the following
// rising edge; a row may request a reset before it is applied. A couple of
// hand-written sequences cover asynchronous reset in the middle of a grant.
// -----------------------------------------------------------------------------
module tb_port_scheduler;

  localparam int NUM_REQ     = 5;
  localparam int MAX_CREDITS = 4;
  localparam int CREDIT_W    = 3;

  typedef struct {
    logic                do_rst;
    logic [NUM_REQ-1:0]  req;
    logic                incr;
    logic [NUM_REQ-1:0]  grant;
    logic [CREDIT_W-1:0] cnt;
    logic                stall;
    logic                err;
  } vec_t;

  logic clk;
  logic rst;

  port_sched_if #(.NUM_REQ(NUM_REQ), .CREDIT_W(CREDIT_W)) bus ();

  port_scheduler #(
    .NUM_REQ     (NUM_REQ),
    .MAX_CREDITS (MAX_CREDITS),
    .CREDIT_W    (CREDIT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [NUM_REQ-1:0] exp_q[$];
  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [NUM_REQ-1:0] rq,
                              input logic inc, input logic [NUM_REQ-1:0] g,
                              input logic [CREDIT_W-1:0] c, input logic s,
                              input logic e);
    vec_t v;
    v.do_rst = r; v.req = rq; v.incr = inc;
    v.grant = g; v.cnt = c; v.stall = s; v.err = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    bus.req_i         = '0;
    bus.credit_incr_i = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_grant", 32'(bus.grant_o), 32'd0);
    chk("rst_gvalid", 32'(bus.grant_valid_o), 32'd0);
    chk("rst_cnt", 32'(bus.credit_cnt_o), 32'(MAX_CREDITS));
    chk("rst_stall", 32'(bus.stall_o), 32'd0);
    chk("rst_err", 32'(bus.credit_err_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic apply(input vec_t v, input int row);
    logic [NUM_REQ-1:0] eg;
    if (v.do_rst) do_reset();
    exp_q.push_back(v.grant);
    @(negedge clk);
    bus.req_i         = v.req;
    bus.credit_incr_i = v.incr;
    @(posedge clk);
    #1;
    eg = exp_q.pop_front();
    chk($sformatf("row%0d_grant", row), 32'(bus.grant_o), 32'(eg));
    chk($sformatf("row%0d_gvalid", row), 32'(bus.grant_valid_o), 32'(|eg));
    chk($sformatf("row%0d_cnt", row), 32'(bus.credit_cnt_o), 32'(v.cnt));
    chk($sformatf("row%0d_stall", row), 32'(bus.stall_o), 32'(v.stall));
    chk($sformatf("row%0d_err", row), 32'(bus.credit_err_o), 32'(v.err));
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    rst               = 1'b1;
    bus.req_i         = '0;
    bus.credit_incr_i = 1'b0;

`ifndef SCHED_LOCAL_PRIO_EN
    // All requesting, credit returned every cycle: strict rotation, count flat.
    tbl.push_back(mk(1, 5'b11111, 1, 5'b00001, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 5'b00010, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 5'b00100, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 5'b01000, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 5'b10000, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b11111, 1, 5'b00001, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 5'b00000, 3'd4, 0, 0));
`endif
    // E alone, no returns: drain credits then stall.
    tbl.push_back(mk(1, 5'b00100, 0, 5'b00100, 3'd3, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 5'b00100, 3'd2, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 5'b00100, 3'd1, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 5'b00100, 3'd0, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 5'b00000, 3'd0, 1, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 5'b00000, 3'd0, 1, 0));
    // One returned credit is spent immediately.
    tbl.push_back(mk(0, 5'b00100, 1, 5'b00100, 3'd0, 0, 0));
    tbl.push_back(mk(0, 5'b00100, 0, 5'b00000, 3'd0, 1, 0));
    tbl.push_back(mk(0, 5'b00000, 0, 5'b00000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 5'b00000, 1, 5'b00000, 3'd1, 0, 0));
    // Return at full count: saturate and raise the sticky error.
    tbl.push_back(mk(1, 5'b00000, 1, 5'b00000, 3'd4, 0, 1));
    tbl.push_back(mk(0, 5'b00000, 0, 5'b00000, 3'd4, 0, 1));
    tbl.push_back(mk(0, 5'b00001, 0, 5'b00001, 3'd3, 0, 1));
    tbl.push_back(mk(0, 5'b00000, 0, 5'b00000, 3'd3, 0, 1));
`ifndef SCHED_LOCAL_PRIO_EN
    // Pointer behaviour: after S, N is next; wrap from L back to N.
    tbl.push_back(mk(1, 5'b00010, 1, 5'b00010, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b00011, 1, 5'b00001, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10000, 1, 5'b10000, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 5'b00001, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 5'b10000, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10001, 1, 5'b00001, 3'd4, 0, 0));
    // Stalled cycles must not advance the pointer: S/W both wait, then resume.
    tbl.push_back(mk(1, 5'b01010, 0, 5'b00010, 3'd3, 0, 0));
    tbl.push_back(mk(0, 5'b01010, 0, 5'b01000, 3'd2, 0, 0));
    tbl.push_back(mk(0, 5'b01010, 0, 5'b00010, 3'd1, 0, 0));
    tbl.push_back(mk(0, 5'b01010, 0, 5'b01000, 3'd0, 0, 0));
    tbl.push_back(mk(0, 5'b01010, 0, 5'b00000, 3'd0, 1, 0));
    tbl.push_back(mk(0, 5'b01010, 1, 5'b00010, 3'd0, 0, 0));
`else
    // Local priority: L,L,S repeating while S also requests.
    tbl.push_back(mk(1, 5'b10010, 1, 5'b10000, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10010, 1, 5'b10000, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10010, 1, 5'b00010, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10010, 1, 5'b10000, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10010, 1, 5'b10000, 3'd4, 0, 0));
    tbl.push_back(mk(0, 5'b10010, 1, 5'b00010, 3'd4, 0, 0));
`endif

    foreach (tbl[i]) apply(tbl[i], i);

    // Hand-written: asynchronous reset while W holds a grant.
    do_reset();
    @(negedge clk);
    bus.req_i = 5'b01000;
    @(posedge clk);
    #1;
    chk("async_pre_grant", 32'(bus.grant_o), 32'(5'b01000));
    chk("async_pre_cnt", 32'(bus.credit_cnt_o), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("async_grant", 32'(bus.grant_o), 32'd0);
    chk("async_gvalid", 32'(bus.grant_valid_o), 32'd0);
    chk("async_cnt", 32'(bus.credit_cnt_o), 32'(MAX_CREDITS));
    bus.req_i = '0;
    @(negedge clk);
    rst = 1'b0;

    // After reset the pointer is back at L, so N is searched first.
    @(negedge clk);
    bus.req_i = 5'b01001;
    @(posedge clk);
    #1;
    chk("post_rst_first", 32'(bus.grant_o), 32'(5'b00001));
    @(negedge clk);
    bus.req_i = '0;

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
